uart_rx: RTL and testbench

Serial receive stage of the UART. Consumes the line driven by the transmit datapath (idle-high; 8N1 frames: one start bit, 8 data bits LSB-first, one stop bit). Recovers each byte by mid-bit sampling against a parameterised baud period. Presents the byte on a valid/ready holding register, with framing-error and overrun flags.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Used by the receive stage and the transmit baud counter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 5;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so no false edge is seen on reset release.
module uart_sync2 (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receive stage with mid-bit sampling.
// Byte is held on a valid/ready register with framing and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       rx_i,
   input  logic       ready_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

   logic                 w_rx_s;
   logic                 r_rx_prev;

   rx_state_e            r_state;
   rx_state_e            w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [2:0]           r_bit;
   logic [2:0]           w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;

   logic                 w_good;
   logic                 w_bad;
   logic                 w_load;
   logic                 w_ovr;

   logic [7:0]           r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;

   uart_sync2 u_sync (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .d_i      (rx_i),
      .q_o      (w_rx_s)
   );

   // Next-state, counter and shift-register logic for the frame FSM
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (!w_rx_s && r_rx_prev) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = w_rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
               w_bit_nxt   = r_bit + 3'd1;
               if (r_bit == BIT_LAST) begin
                  w_state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               w_good      = w_rx_s;
               w_bad       = !w_rx_s;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // A good frame loads only if the holding register is free this cycle
   assign w_load = w_good && (!r_valid || ready_i);
   assign w_ovr  = w_good && !w_load;

   // FSM, counters, shift register, holding register and flag pulses
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_rx_prev   <= 1'b1;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_rx_prev   <= w_rx_s;
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit       <= w_bit_nxt;
         r_shift     <= w_shift_nxt;
         r_frame_err <= w_bad;
         r_overrun   <= w_ovr;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// Frames are driven LSB-first, C cycles per bit, aligned to clock edges.
module tb_uart_rx;

   localparam int C = 5;

   logic       clk_i;
   logic       reset_ni;
   logic       rx_i;
   logic       ready_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;

   int pass_cnt;
   int total_cnt;
   int fe_cnt;
   int ov_cnt;
   int both_cnt;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .rx_i        (rx_i),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Count flag-high cycles away from the active edge
   always @(negedge clk_i) begin
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (frame_err_o && overrun_o) both_cnt++;
   end

   // Advance n cycles, leaving time at #1 after the last edge
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Drive one frame starting #1 after an edge; returns #1 after
   // edge N0+49 (stop sample). v48 is valid_o just after edge N0+48.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             output logic v48);
      logic [9:0] f;
      f   = {stop, b, 1'b0};
      v48 = 1'bx;
      for (int i = 0; i < 10; i++) begin
         rx_i = f[i];
         for (int j = 0; j < C; j++) begin
            @(posedge clk_i);
            #1;
            if (i == 9 && j == C - 2) v48 = valid_o;
         end
      end
   endtask

   task automatic test_reset;
      reset_ni = 1'b0;
      rx_i     = 1'b1;
      ready_i  = 1'b0;
      cycles(3);
      total_cnt++;
      if ({data_o, valid_o, frame_err_o, overrun_o} !== 11'd0)
         $display("FAIL reset_outputs got=%h exp=000",
                  {data_o, valid_o, frame_err_o, overrun_o});
      else pass_cnt++;
      reset_ni = 1'b1;
      cycles(5);
   endtask

   task automatic test_single;
      logic v48;
      int   fe0, ov0;
      ready_i = 1'b1;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(8'hA5, 1'b1, v48);
      total_cnt++;
      if (v48 !== 1'b0) $display("FAIL single_early got=%b exp=0", v48);
      else pass_cnt++;
      total_cnt++;
      if (valid_o !== 1'b1 || data_o !== 8'hA5)
         $display("FAIL single_byte got=%b/%h exp=1/a5", valid_o, data_o);
      else pass_cnt++;
      cycles(2);
      total_cnt++;
      if (valid_o !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0)
         $display("FAIL single_after got=%b/%0d/%0d exp=0/%0d/%0d",
                  valid_o, fe_cnt, ov_cnt, fe0, ov0);
      else pass_cnt++;
   endtask

   task automatic test_glitch;
      logic v48;
      int   fe0, ov0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx_i = 1'b0;
      cycles(1);
      rx_i = 1'b1;
      cycles(60);
      total_cnt++;
      if (valid_o !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0)
         $display("FAIL glitch_quiet got=%b/%0d/%0d exp=0/%0d/%0d",
                  valid_o, fe_cnt, ov_cnt, fe0, ov0);
      else pass_cnt++;
      send_frame(8'h3C, 1'b1, v48);
      total_cnt++;
      if (v48 !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h3C)
         $display("FAIL glitch_then_byte got=%b/%b/%h exp=0/1/3c",
                  v48, valid_o, data_o);
      else pass_cnt++;
      cycles(3);
   endtask

   task automatic test_frame_err;
      logic v48;
      int   fe0;
      fe0 = fe_cnt;
      send_frame(8'h81, 1'b0, v48);
      total_cnt++;
      if (frame_err_o !== 1'b1 || valid_o !== 1'b0)
         $display("FAIL frame_err_pulse got=%b/%b exp=1/0",
                  frame_err_o, valid_o);
      else pass_cnt++;
      cycles(20);
      total_cnt++;
      if (fe_cnt != fe0 + 1 || valid_o !== 1'b0 || frame_err_o !== 1'b0)
         $display("FAIL frame_err_break got=%0d/%b exp=%0d/0",
                  fe_cnt - fe0, valid_o, 1);
      else pass_cnt++;
      rx_i = 1'b1;
      cycles(5);
      send_frame(8'h42, 1'b1, v48);
      total_cnt++;
      if (valid_o !== 1'b1 || data_o !== 8'h42 || fe_cnt != fe0 + 1)
         $display("FAIL frame_err_recover got=%b/%h exp=1/42",
                  valid_o, data_o);
      else pass_cnt++;
      cycles(3);
   endtask

   task automatic test_overrun;
      logic v48;
      int   ov0;
      ov0 = ov_cnt;
      ready_i = 1'b0;
      send_frame(8'h11, 1'b1, v48);
      total_cnt++;
      if (valid_o !== 1'b1 || data_o !== 8'h11)
         $display("FAIL overrun_first got=%b/%h exp=1/11", valid_o, data_o);
      else pass_cnt++;
      send_frame(8'h22, 1'b1, v48);
      total_cnt++;
      if (overrun_o !== 1'b1 || data_o !== 8'h11 || valid_o !== 1'b1)
         $display("FAIL overrun_pulse got=%b/%h/%b exp=1/11/1",
                  overrun_o, data_o, valid_o);
      else pass_cnt++;
      ready_i = 1'b1;
      cycles(1);
      total_cnt++;
      if (valid_o !== 1'b0 || overrun_o !== 1'b0 || ov_cnt != ov0 + 1)
         $display("FAIL overrun_drain got=%b/%b/%0d exp=0/0/1",
                  valid_o, overrun_o, ov_cnt - ov0);
      else pass_cnt++;
      cycles(3);
   endtask

   task automatic test_reset_mid;
      logic v48;
      ready_i = 1'b0;
      rx_i = 1'b0;
      cycles(C * 5);
      rx_i = 1'b1;
      cycles(2);
      #2;
      reset_ni = 1'b0;
      #1;
      total_cnt++;
      if ({data_o, valid_o, frame_err_o, overrun_o} !== 11'd0)
         $display("FAIL reset_mid got=%h exp=000",
                  {data_o, valid_o, frame_err_o, overrun_o});
      else pass_cnt++;
      cycles(2);
      reset_ni = 1'b1;
      ready_i = 1'b1;
      cycles(4);
      send_frame(8'h5A, 1'b1, v48);
      total_cnt++;
      if (v48 !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h5A)
         $display("FAIL reset_then_byte got=%b/%b/%h exp=0/1/5a",
                  v48, valid_o, data_o);
      else pass_cnt++;
      cycles(3);
   endtask

   task automatic test_back_to_back;
      logic [7:0] vec [3];
      logic       v48;
      int         fe0, ov0;
      vec[0] = 8'h00;
      vec[1] = 8'hFF;
      vec[2] = 8'h55;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send_frame(vec[k], 1'b1, v48);
         total_cnt++;
         if (v48 !== 1'b0 || valid_o !== 1'b1 || data_o !== vec[k])
            $display("FAIL loopback_%0d got=%b/%b/%h exp=0/1/%h",
                     k, v48, valid_o, data_o, vec[k]);
         else pass_cnt++;
      end
      cycles(3);
      total_cnt++;
      if (fe_cnt != fe0 || ov_cnt != ov0 || both_cnt != 0)
         $display("FAIL loopback_flags got=%0d/%0d/%0d exp=0/0/0",
                  fe_cnt - fe0, ov_cnt - ov0, both_cnt);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      fe_cnt    = 0;
      ov_cnt    = 0;
      both_cnt  = 0;
      reset_ni  = 1'b0;
      rx_i      = 1'b1;
      ready_i   = 1'b0;
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
